mem_controller: RTL

Request/response front end sitting directly upstream of the NBBPU data RAM; the NBBPU core issues load/store requests here instead of driving the RAM pins directly. It decodes each address to RAM, a single memory-mapped output register, or an unmapped region. It sequences the RAM's one-cycle registered read, and returns a single response pulse per request. It handles one request at a time; there is no pipelining.

---
 rtl/mem_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// mem_controller: single-outstanding load/store front end for the NBBPU data RAM.
// Each request is decoded to the RAM, to the memory-mapped io_out register, or to
// an unmapped region. The controller sequences the RAM's registered read and
// returns exactly one resp_valid pulse per request.
module mem_controller #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_address,
    input  logic [15:0] req_data,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_error,
    output logic        ram_select,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    output logic [15:0] ram_address,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data,
    output logic [15:0] io_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // One more bit than the address so a full 16-bit RAM range is representable.
    localparam logic [16:0] RAM_WORDS = 17'(1) << ADDR_BITS;

    state_t state;
    logic   write_q;
    logic   is_ram;
    logic   is_io;

    assign req_ready = (state == IDLE);

    // Address decode; the RAM range takes priority if IO_ADDR overlaps it.
    always_comb begin
        is_ram = ({1'b0, req_address} < RAM_WORDS);
        is_io  = !is_ram && (req_address == IO_ADDR);
    end

    // Request FSM with registered RAM strobes and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            write_q          <= 1'b0;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_data        <= 16'h0000;
            ram_select       <= 1'b0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_address      <= 16'h0000;
            ram_write_data   <= 16'h0000;
            io_out           <= 16'h0000;
        end else begin
            // Strobes and the response pulse are single-cycle by default.
            ram_select       <= 1'b0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            resp_valid       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        if (is_ram) begin
                            ram_select       <= 1'b1;
                            ram_read_enable  <= ~req_write;
                            ram_write_enable <= req_write;
                            ram_address      <= req_address;
                            ram_write_data   <= req_data;
                            state            <= ISSUE;
                        end else if (is_io) begin
                            if (req_write) begin
                                io_out    <= req_data;
                                resp_data <= 16'h0000;
                            end else begin
                                resp_data <= io_out;
                            end
                            resp_error <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            // Unmapped: report an error without touching RAM or io_out.
                            resp_data  <= 16'h0000;
                            resp_error <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (write_q) begin
                        resp_data  <= 16'h0000;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // RAM read data became valid on the ISSUE->WAIT edge.
                    resp_data  <= ram_read_data;
                    resp_error <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
